// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the single-cycle RV32 core. It holds the PC and
// fetches one instruction word at a time over a valid/ready request and valid
// response interface. The word is presented to decode, together with the
// op/funct3/funct7[5] fields that the control unit needs. When decode reports
// that the instruction has retired, the next PC is selected. That is either
// pc + 4 or the branch target pc + imm_ext.
//
// Parameters
//   RESET_PC        PC loaded on reset (must be word-aligned)
//   NOP_INSTR       value held in instr after reset (addi x0,x0,0)
//
// Ports
//   clk             core clock, all state changes on the rising edge
//   reset           synchronous, active-high
//   imem_req_valid  fetch request pending
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   byte address of the requested word ([1:0] = 0)
//   imem_rsp_valid  response data valid
//   imem_rsp_data   instruction word returned by memory
//   retire          datapath has finished the presented instruction
//   pc_src          1 = take the branch (Branch & Zero)
//   imm_ext         sign-extended branch offset
//   instr_valid     instr/pc hold a fetched instruction
//   instr           current instruction
//   op              instr[6:0]
//   funct3          instr[14:12]
//   funct7          instr[30]
//   pc              address of instr
//   pc_plus4        pc + 4, used for the jal/jalr link value
//   fetch_fault     sticky fault after a retire toward a misaligned target
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        retire,
   input  logic        pc_src,
   input  logic [31:0] imm_ext,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic        funct7,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD,
      FAULT
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] next_pc;
   logic        capture;
   logic        load_pc;

   // Candidate next PC. It is only consumed in HOLD on retire. The additions
   // wrap modulo 2^32, so a negative offset or the top word both roll over.
   always_comb begin
      next_pc = pc_src ? (pc_q + imm_ext) : (pc_q + 32'd4);
   end

   // Next-state logic. The request valid is asserted throughout REQ, so
   // acceptance only depends on ready. A response outside WAIT is dropped by
   // construction. Only reset leaves FAULT. A misaligned target goes to
   // FAULT and leaves the PC unchanged.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      load_pc = 1'b0;
      case (state_q)
         REQ: begin
            if (imem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               capture = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (retire) begin
               if (next_pc[1:0] == 2'b00) begin
                  load_pc = 1'b1;
                  state_d = REQ;
               end else begin
                  state_d = FAULT;
               end
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = REQ;
         end
      endcase
   end

   // State, PC and instruction registers. Reset from any state restarts the
   // fetch at RESET_PC. The memory shares this reset and drops whatever
   // response was outstanding, so nothing here needs draining.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         if (capture) begin
            instr_q <= imem_rsp_data;
         end
         if (load_pc) begin
            pc_q <= next_pc;
         end
      end
   end

   // Outputs are decoded straight from registered state. instr, pc and
   // instr_valid therefore only move on clock edges. The request valid is
   // gated by reset so no request leaks out while reset is held.
   always_comb begin
      imem_req_valid = (state_q == REQ) && !reset;
      imem_req_addr  = pc_q;
      instr_valid    = (state_q == HOLD);
      fetch_fault    = (state_q == FAULT);
      instr          = instr_q;
      op             = instr_q[6:0];
      funct3         = instr_q[14:12];
      funct7         = instr_q[30];
      pc             = pc_q;
      pc_plus4       = pc_q + 32'd4;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A second instance with RESET_PC at the top
// word covers the PC wrap. Inputs are driven 1 time unit after the rising
// edge, and outputs are sampled away from the edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        retire = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] imm_ext = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_fault;

   logic        wReqValid;
   logic        wReqReady = 1'b0;
   logic [31:0] wReqAddr;
   logic        wRspValid = 1'b0;
   logic [31:0] wRspData = 32'h0;
   logic        wRetire = 1'b0;
   logic        wInstrValid;
   logic [31:0] wInstr;
   logic [6:0]  wOp;
   logic [2:0]  wFunct3;
   logic        wFunct7;
   logic [31:0] wPc;
   logic [31:0] wPcPlus4;
   logic        wFault;

   int testsRun = 0;
   int failCount = 0;
   int lowCount = 0;
   int lastGap = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .retire(retire), .pc_src(pc_src),
      .imm_ext(imm_ext), .instr_valid(instr_valid), .instr(instr), .op(op),
      .funct3(funct3), .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4),
      .fetch_fault(fetch_fault)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .reset(reset),
      .imem_req_valid(wReqValid), .imem_req_ready(wReqReady),
      .imem_req_addr(wReqAddr), .imem_rsp_valid(wRspValid),
      .imem_rsp_data(wRspData), .retire(wRetire), .pc_src(1'b0),
      .imm_ext(32'h0), .instr_valid(wInstrValid), .instr(wInstr), .op(wOp),
      .funct3(wFunct3), .funct7(wFunct7), .pc(wPc), .pc_plus4(wPcPlus4),
      .fetch_fault(wFault)
   );

   // Count instr_valid-low cycles between instructions, measured on the
   // falling edge. Reset clears the count so the first gap starts at release.
   always @(negedge clk) begin
      if (reset) begin
         lowCount = 0;
      end else if (!instr_valid) begin
         lowCount = lowCount + 1;
      end else if (lowCount != 0) begin
         lastGap  = lowCount;
         lowCount = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Serve one fetch, starting in REQ just after an edge. The ready line is
   // held low for stallCycles, then the request is accepted. The response
   // comes rspDelay cycles after the first WAIT cycle. The task ends in HOLD
   // after the falling edge, and then checks the measured instr_valid gap.
   task automatic applyStimulus(input logic [31:0] expAddr, input logic [31:0] data,
                                input int stallCycles, input int rspDelay,
                                input int expGap);
      imem_req_ready = 1'b0;
      for (int i = 0; i < stallCycles; i++) begin
         #1;
         checkOutput("stallValid", {31'b0, imem_req_valid}, 32'd1);
         checkOutput("stallAddr", imem_req_addr, expAddr);
         nextCycle();
      end
      imem_req_ready = 1'b1;
      #1;
      checkOutput("reqValid", {31'b0, imem_req_valid}, 32'd1);
      checkOutput("reqAddr", imem_req_addr, expAddr);
      nextCycle();
      imem_req_ready = 1'b0;
      checkOutput("waitNoReq", {31'b0, imem_req_valid}, 32'd0);
      for (int i = 0; i < rspDelay; i++) begin
         nextCycle();
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      nextCycle();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      #1;
      checkOutput("holdValid", {31'b0, instr_valid}, 32'd1);
      checkOutput("instr", instr, data);
      checkOutput("pc", pc, expAddr);
      checkOutput("gap", lastGap, expGap);
   endtask

   task automatic retireWith(input logic src, input logic [31:0] imm);
      retire  = 1'b1;
      pc_src  = src;
      imm_ext = imm;
      nextCycle();
      retire  = 1'b0;
      pc_src  = 1'b0;
      imm_ext = 32'h0;
   endtask

   initial begin
      // Reset state
      nextCycle();
      nextCycle();
      checkOutput("rstReqValid", {31'b0, imem_req_valid}, 32'd0);
      checkOutput("rstInstrValid", {31'b0, instr_valid}, 32'd0);
      checkOutput("rstFault", {31'b0, fetch_fault}, 32'd0);
      checkOutput("rstInstr", instr, NOP);
      checkOutput("rstPc", pc, 32'h0);
      reset = 1'b0;

      // First fetch, zero-wait memory
      applyStimulus(32'h0, 32'h0050_0093, 0, 0, 2);
      checkOutput("op0", {25'b0, op}, 32'h13);
      checkOutput("funct3_0", {29'b0, funct3}, 32'h0);
      checkOutput("funct7_0", {31'b0, funct7}, 32'h0);
      checkOutput("pcPlus4_0", pc_plus4, 32'h4);

      // Sequential fetches, one with a ready stall and one with a slow response
      retireWith(1'b0, 32'h0);
      applyStimulus(32'h4, 32'h4020_8133, 0, 0, 2);
      checkOutput("op1", {25'b0, op}, 32'h33);
      checkOutput("funct7_1", {31'b0, funct7}, 32'h1);
      retireWith(1'b0, 32'h0);
      applyStimulus(32'h8, 32'h0020_9463, 3, 0, 5);
      checkOutput("funct3_2", {29'b0, funct3}, 32'h1);
      checkOutput("op2", {25'b0, op}, 32'h63);
      retireWith(1'b0, 32'h0);
      applyStimulus(32'hC, 32'h00C5_8593, 0, 1, 3);
      retireWith(1'b0, 32'h0);
      applyStimulus(32'h10, NOP, 0, 0, 2);

      // Branches: backward, forward, and a large backward offset to 0x20
      retireWith(1'b1, 32'hFFFF_FFF8);
      applyStimulus(32'h8, NOP, 0, 0, 2);
      retireWith(1'b1, 32'h8);
      applyStimulus(32'h10, NOP, 0, 0, 2);
      retireWith(1'b1, 32'h100);
      applyStimulus(32'h110, NOP, 0, 0, 2);
      checkOutput("pcPlus4_110", pc_plus4, 32'h114);
      retireWith(1'b1, 32'hFFFF_FF10);
      applyStimulus(32'h20, 32'h0000_6063, 0, 0, 2);

      // Misaligned target: sticky fault, no requests, PC unchanged
      retireWith(1'b1, 32'h6);
      imem_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         retire = 1'b1;
         #1;
         checkOutput("faultFlag", {31'b0, fetch_fault}, 32'd1);
         checkOutput("faultNoValid", {31'b0, instr_valid}, 32'd0);
         checkOutput("faultNoReq", {31'b0, imem_req_valid}, 32'd0);
         checkOutput("faultPc", pc, 32'h20);
         nextCycle();
      end
      retire = 1'b0;
      imem_req_ready = 1'b0;
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      checkOutput("faultCleared", {31'b0, fetch_fault}, 32'd0);
      applyStimulus(32'h0, 32'h0010_0113, 0, 0, 2);

      // Reset while a response is outstanding, then a stray response
      retireWith(1'b0, 32'h0);
      imem_req_ready = 1'b1;
      nextCycle();
      imem_req_ready = 1'b0;
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      #1;
      checkOutput("rwReqValid", {31'b0, imem_req_valid}, 32'd1);
      checkOutput("rwReqAddr", imem_req_addr, 32'h0);
      checkOutput("rwInstrNop", instr, NOP);
      nextCycle();
      imem_rsp_valid = 1'b0;
      checkOutput("strayIgnored", instr, NOP);
      checkOutput("strayNoValid", {31'b0, instr_valid}, 32'd0);
      applyStimulus(32'h0, 32'h0030_0193, 0, 0, 3);

      // PC wrap on the second instance
      #1;
      checkOutput("wrapReqAddr", wReqAddr, 32'hFFFF_FFFC);
      wReqReady = 1'b1;
      nextCycle();
      wReqReady = 1'b0;
      wRspValid = 1'b1;
      wRspData  = 32'h0000_0013;
      nextCycle();
      wRspValid = 1'b0;
      checkOutput("wrapValid", {31'b0, wInstrValid}, 32'd1);
      checkOutput("wrapPcPlus4", wPcPlus4, 32'h0);
      wRetire = 1'b1;
      nextCycle();
      wRetire = 1'b0;
      #1;
      checkOutput("wrapNextValid", {31'b0, wReqValid}, 32'd1);
      checkOutput("wrapNextAddr", wReqAddr, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RV32 core. Holds the PC, fetches one instruction word at a time from instruction memory over a valid/ready request and valid response interface, and presents the instruction to decode. It splits out the op, funct3 and funct7[5] fields that the control unit consumes. It also consumes the control unit's PCSrc together with the datapath's ImmExt to select the next PC when the current instruction retires.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, value held in `instr` after reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request pending.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word address of request (byte address, [1:0]=0).
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  instruction word.
- retire  in  1  datapath has finished executing the presented instruction.
- pc_src  in  1  from control unit (Branch & Zero); 1 = take branch.
- imm_ext  in  32  sign-extended branch offset from the immediate extender.
- instr_valid  out  1  `instr`/`pc` hold a fetched instruction.
- instr  out  32  current instruction.
- op  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  1  instr[30].
- pc  out  32  address of `instr`.
- pc_plus4  out  32  pc + 4, for jal/jalr link writeback.
- fetch_fault  out  1  sticky misaligned-target fault.

## Operation
- States: REQ, WAIT, HOLD, FAULT. Reset -> REQ.
- REQ: imem_req_valid = 1 (forced 0 while reset is high), imem_req_addr = pc. On valid & ready -> WAIT. Addr and valid are held stable while ready = 0.
- WAIT: no request. On imem_rsp_valid -> capture imem_rsp_data into instr, -> HOLD. A response arriving in any other state is ignored.
- HOLD: instr_valid = 1. On retire, compute next = pc_src ? pc + imm_ext : pc + 4.
  - If next[1:0] == 0: load pc <= next and go to REQ.
  - Otherwise: go to FAULT; pc is unchanged.
- retire, pc_src and imm_ext are sampled only in HOLD; in all other states they are ignored.
- FAULT: fetch_fault = 1, instr_valid = 0, no requests. Only reset exits FAULT.
- Arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000. A negative imm_ext wraps the same way.
- op, funct3 and funct7 are combinational slices of the instr register. pc_plus4 = pc + 4, combinational.
- Reset values: pc = RESET_PC, instr = NOP_INSTR, instr_valid = 0, fetch_fault = 0, imem_req_valid = 0.
- Reset mid-operation (any state, including WAIT with a request outstanding): the next state is REQ at RESET_PC. Instruction memory shares this reset and cancels outstanding responses. The unit does not drain.
- At most one request is outstanding at any time.

## Timing
- Response is legal no earlier than the cycle after request acceptance.
- Zero-wait memory (ready = 1, response one cycle after acceptance):
  - retire sampled at edge E0 -> REQ in cycle E0..E1.
  - Request accepted at E1 -> WAIT; rsp_valid in cycle E1..E2.
  - Edge E2 -> HOLD with instr_valid = 1.
  - instr_valid is low for exactly 2 cycles between consecutive instructions.
- First instr_valid after reset deasserts: 2 cycles minimum.
- Each extra cycle of ready = 0 or of response delay adds exactly one cycle.
- instr, pc and instr_valid change only on clock edges. They are stable throughout HOLD.

## Test plan
- Reset release, ready = 1, rsp = 32'h00500093 one cycle after acceptance -> req addr 0x0; instr_valid rises 2 cycles after reset low; op = 7'h13, funct3 = 0, funct7 = 0, pc = 0, pc_plus4 = 4.
- Sequential: retire with pc_src = 0 three times -> req addrs 0x0, 0x4, 0x8, 0xC; ready held low 3 cycles on 0x8 -> addr 0x8 held stable, instr_valid gap grows to 5 cycles.
- Branch: pc = 0x10, retire with pc_src = 1, imm_ext = 32'hFFFF_FFF8 -> next req addr 0x08. Same with imm_ext = 0x100 -> 0x110.
- Wrap: RESET_PC = 32'hFFFF_FFFC, retire with pc_src = 0 -> next req addr 0x0000_0000.
- Misaligned: pc = 0x20, retire with pc_src = 1, imm_ext = 0x6 -> fetch_fault = 1, instr_valid = 0, no further requests. Then reset -> fetch_fault = 0 and fetch resumes at RESET_PC.
- Reset in WAIT: assert reset for one cycle while a request is outstanding, with a stray rsp_valid the cycle after -> rsp ignored, new request at RESET_PC, instr = NOP_INSTR until the new response arrives.
